// File: rtl/xbar_bridge_pkg.sv
// Shared types and helpers for the XBAR_BRIDGE round-robin arbiter and response router.
package xbar_bridge_pkg;

    localparam int N_MASTER_DFLT = 16;
    localparam int IDX_W_DFLT    = $clog2(N_MASTER_DFLT);

    // Initiator index for the default bridge configuration.
    typedef logic [IDX_W_DFLT-1:0] mst_idx_t;

    // Round-robin successor: idx+1, wrapping n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb_resp_route_bridge_if.sv
// Initiator-side and slave-side bus of the bridge; the slave modport is the bridge's own view.
interface rr_arb_resp_route_bridge_if #(
    parameter int N_MASTER   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int AUX_WIDTH  = 8
);
    logic [N_MASTER-1:0]                 data_req_i;
    logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
    logic [N_MASTER-1:0]                 data_wen_i;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
    logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
    logic [N_MASTER-1:0][AUX_WIDTH-1:0]  data_aux_i;
    logic [N_MASTER-1:0]                 data_gnt_o;
    logic [N_MASTER-1:0]                 data_r_valid_o;
    logic [DATA_WIDTH-1:0]               data_r_rdata_o;
    logic                                data_r_opc_o;
    logic [AUX_WIDTH-1:0]                data_r_aux_o;

    logic                                data_req_o;
    logic [ADDR_WIDTH-1:0]               data_add_o;
    logic                                data_wen_o;
    logic [DATA_WIDTH-1:0]               data_wdata_o;
    logic [BE_WIDTH-1:0]                 data_be_o;
    logic [AUX_WIDTH-1:0]                data_aux_o;
    logic                                data_gnt_i;
    logic                                data_r_valid_i;
    logic [DATA_WIDTH-1:0]               data_r_rdata_i;
    logic                                data_r_opc_i;
    logic [AUX_WIDTH-1:0]                data_r_aux_i;

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
        output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_aux_o,
        output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
        input  data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_aux_i
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
        input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_aux_o,
        input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
        output data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_aux_i
    );

endinterface

// File: rtl/id_fifo_bridge.sv
// In-order FIFO of initiator IDs for accepted requests; head names the owner of the next response.
module id_fifo_bridge #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rr_arb_resp_route_bridge.sv
// Round-robin arbiter with grant lock sharing one slave port, plus in-order response routing
// back to the initiator recorded at the head of the ID FIFO.
module rr_arb_resp_route_bridge
    import xbar_bridge_pkg::*;
#(
    parameter int N_MASTER        = N_MASTER_DFLT,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int AUX_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    rr_arb_resp_route_bridge_if.slave            bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 resp_err_o
);
    localparam int IDX_W = $clog2(N_MASTER);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t rr_ptr;
    idx_t locked_idx;
    idx_t winner;
    idx_t head_idx;
    logic lock;
    logic fifo_full;
    logic fifo_empty;
    logic handshake;
    logic resp_pop;

    // Scan from the highest offset down so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin : arbitrate
        int cand;
        cand = 0;
        // NOTE: winner gets a default before any branch, so no path can infer a latch.
        winner = rr_ptr;
        if (lock) begin
            winner = locked_idx;
        end else begin
            for (int k = N_MASTER - 1; k >= 0; k--) begin
                cand = int'(rr_ptr) + k;
                if (cand >= N_MASTER) cand = cand - N_MASTER;
                if (bus.data_req_i[idx_t'(cand)]) winner = idx_t'(cand);
            end
        end
    end

    assign bus.data_req_o   = (|bus.data_req_i || lock) && !fifo_full;
    assign handshake        = bus.data_req_o && bus.data_gnt_i;
    assign bus.data_add_o   = bus.data_add_i[winner];
    assign bus.data_wen_o   = bus.data_wen_i[winner];
    assign bus.data_wdata_o = bus.data_wdata_i[winner];
    assign bus.data_be_o    = bus.data_be_i[winner];
    assign bus.data_aux_o   = bus.data_aux_i[winner];

    always_comb begin
        bus.data_gnt_o = '0;
        if (handshake) bus.data_gnt_o[winner] = 1'b1;
    end

    // Responses are routed to the old head even when a grant pushes in the same cycle.
    assign resp_pop = bus.data_r_valid_i && !fifo_empty;

    always_comb begin
        bus.data_r_valid_o = '0;
        if (resp_pop) bus.data_r_valid_o[head_idx] = 1'b1;
    end

    assign bus.data_r_rdata_o = bus.data_r_rdata_i;
    assign bus.data_r_opc_o   = bus.data_r_opc_i;
    assign bus.data_r_aux_o   = bus.data_r_aux_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            resp_err_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            if (handshake) begin
                rr_ptr <= idx_t'(rr_next(int'(winner), N_MASTER));
                lock   <= 1'b0;
            end else if (bus.data_req_o) begin
                lock       <= 1'b1;
                locked_idx <= winner;
            end
            if (bus.data_r_valid_i && fifo_empty) resp_err_o <= 1'b1;
        end
    end

    id_fifo_bridge #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (handshake),
        .push_data (winner),
        .pop       (resp_pop),
        .head      (head_idx),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding_o)
    );

endmodule

// File: tb/tb_rr_arb_resp_route_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rr_arb_resp_route_bridge;

    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int XW = 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] outstanding;
    logic          resp_err;

    always #5 clk = ~clk;

    rr_arb_resp_route_bridge_if #(
        .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .AUX_WIDTH(XW)
    ) bus ();

    rr_arb_resp_route_bridge #(
        .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .AUX_WIDTH(XW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .outstanding_o (outstanding),
        .resp_err_o    (resp_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pointer, lock, ID queue and sticky error.
    int m_ptr;
    bit m_lock;
    int m_locked;
    int m_fifo[$];
    bit m_err;

    int cyc = 0;
    int auto_lat = 0;
    int due_q[$];
    int id_q[$];
    int obs_gnt[$];
    int obs_rv[$];
    logic [N-1:0] last_gnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int model_winner();
        if (m_lock) return m_locked;
        for (int k = 0; k < N; k++) begin
            if (bus.data_req_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.data_req_i     = '0;
        bus.data_add_i     = '0;
        bus.data_wen_i     = '0;
        bus.data_wdata_i   = '0;
        bus.data_be_i      = '0;
        bus.data_aux_i     = '0;
        bus.data_gnt_i     = 1'b0;
        bus.data_r_valid_i = 1'b0;
        bus.data_r_rdata_i = '0;
        bus.data_r_opc_i   = 1'b0;
        bus.data_r_aux_i   = '0;
    endtask

    task automatic raise(input int i);
        bus.data_req_i[i]   = 1'b1;
        bus.data_add_i[i]   = $urandom;
        bus.data_wen_i[i]   = 1'($urandom_range(0, 1));
        bus.data_wdata_i[i] = $urandom;
        bus.data_be_i[i]    = BW'($urandom);
        bus.data_aux_i[i]   = XW'($urandom);
    endtask

    task automatic drop_granted();
        if (last_gnt != '0) bus.data_req_i[onehot_idx(last_gnt)] = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        auto_lat = 0;
        due_q.delete();
        id_q.delete();
        rst_n = 1'b0;
        #2;
        check("rst_outstanding", outstanding, 0);
        check("rst_err", resp_err, 0);
        check("rst_req_o", bus.data_req_o, 0);
        check("rst_gnt_o", bus.data_gnt_o, 0);
        m_ptr = 0;
        m_lock = 0;
        m_fifo.delete();
        m_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_gnt.delete();
        obs_rv.delete();
    endtask

    // One clock: inputs already set; compare at negedge, update the model at posedge.
    task automatic cycle();
        int w;
        bit ereq;
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        if (auto_lat > 0) begin
            bus.data_r_valid_i = (due_q.size() > 0) && (due_q[0] <= cyc);
            bus.data_r_rdata_i = bus.data_r_valid_i ? 32'hA5A5_0000 + id_q[0] : '0;
            bus.data_r_opc_i   = 1'b0;
            bus.data_r_aux_i   = bus.data_r_valid_i ? XW'(id_q[0]) : '0;
        end
        @(negedge clk);
        w    = model_winner();
        ereq = (w >= 0) && (m_fifo.size() < MO);
        eg   = '0;
        erv  = '0;
        if (ereq && bus.data_gnt_i) eg[w] = 1'b1;
        if (bus.data_r_valid_i && m_fifo.size() > 0) erv[m_fifo[0]] = 1'b1;
        check("req_o", bus.data_req_o, ereq);
        check("gnt_o", bus.data_gnt_o, eg);
        check("r_valid_o", bus.data_r_valid_o, erv);
        check("r_rdata_o", bus.data_r_rdata_o, bus.data_r_rdata_i);
        check("r_opc_o", bus.data_r_opc_o, bus.data_r_opc_i);
        check("r_aux_o", bus.data_r_aux_o, bus.data_r_aux_i);
        check("outstanding", outstanding, m_fifo.size());
        check("resp_err", resp_err, m_err);
        if (ereq) begin
            check("add_o", bus.data_add_o, bus.data_add_i[w]);
            check("wen_o", bus.data_wen_o, bus.data_wen_i[w]);
            check("wdata_o", bus.data_wdata_o, bus.data_wdata_i[w]);
            check("be_o", bus.data_be_o, bus.data_be_i[w]);
            check("aux_o", bus.data_aux_o, bus.data_aux_i[w]);
        end
        if (auto_lat > 0 && bus.data_r_valid_o != '0)
            check("route_rdata", bus.data_r_rdata_o, 32'hA5A5_0000 + onehot_idx(bus.data_r_valid_o));
        if (bus.data_gnt_o != '0) obs_gnt.push_back(onehot_idx(bus.data_gnt_o));
        if (bus.data_r_valid_o != '0) obs_rv.push_back(onehot_idx(bus.data_r_valid_o));
        @(posedge clk);
        if (bus.data_r_valid_i) begin
            if (m_fifo.size() > 0) void'(m_fifo.pop_front());
            else m_err = 1'b1;
            if (auto_lat > 0) begin
                void'(due_q.pop_front());
                void'(id_q.pop_front());
            end
        end
        if (ereq && bus.data_gnt_i) begin
            m_fifo.push_back(w);
            m_ptr  = (w + 1) % N;
            m_lock = 1'b0;
            if (auto_lat > 0) begin
                due_q.push_back(cyc + auto_lat);
                id_q.push_back(w);
            end
        end else if (ereq) begin
            m_lock   = 1'b1;
            m_locked = w;
        end
        last_gnt = eg;
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int g = 0; g < MO + 2 && m_fifo.size() > 0; g++) begin
            bus.data_r_valid_i = 1'b1;
            bus.data_r_rdata_i = $urandom;
            bus.data_r_opc_i   = 1'($urandom_range(0, 1));
            bus.data_r_aux_i   = XW'($urandom);
            cycle();
        end
        bus.data_r_valid_i = 1'b0;
    endtask

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    initial begin
        int exp_order[6];
        exp_order = '{0, 3, 5, 0, 3, 5};

        // Round-robin among 0, 3, 5 with 2-cycle responses.
        apply_reset();
        auto_lat = 2;
        bus.data_gnt_i = 1'b1;
        raise(0); raise(3); raise(5);
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (last_gnt != '0) raise(onehot_idx(last_gnt));
        end
        bus.data_req_i = '0;
        for (int c = 0; c < 4; c++) cycle();
        for (int k = 0; k < 6; k++) begin
            check("rr_gnt_order", at(obs_gnt, k), exp_order[k]);
            check("rr_rvalid_order", at(obs_rv, k), exp_order[k]);
        end
        auto_lat = 0;

        // Lock: master 2 stalled, master 1 joins; 2 must be granted first.
        apply_reset();
        raise(2);
        cycle();
        raise(1);
        cycle();
        cycle();
        bus.data_gnt_i = 1'b1;
        cycle(); drop_granted();
        cycle(); drop_granted();
        check("lock_first", at(obs_gnt, 0), 2);
        check("lock_second", at(obs_gnt, 1), 1);
        drain();

        // FIFO full after 4 grants; one response frees a slot for the 5th.
        apply_reset();
        bus.data_gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) raise(i);
        for (int c = 0; c < 5; c++) begin
            cycle(); drop_granted();
        end
        check("full_outstanding", outstanding, 4);
        check("full_req_o", bus.data_req_o, 0);
        check("full_gnt_o", bus.data_gnt_o, 0);
        bus.data_r_valid_i = 1'b1;
        cycle();
        bus.data_r_valid_i = 1'b0;
        check("after_pop_outstanding", outstanding, 3);
        cycle(); drop_granted();
        check("fifth_grant", at(obs_gnt, 4), 4);
        drain();

        // Grant and response in the same cycle at occupancy 2.
        apply_reset();
        bus.data_gnt_i = 1'b1;
        raise(6); raise(7);
        cycle(); drop_granted();
        cycle(); drop_granted();
        raise(8);
        bus.data_r_valid_i = 1'b1;
        cycle(); drop_granted();
        bus.data_r_valid_i = 1'b0;
        check("pushpop_outstanding", outstanding, 2);
        check("pushpop_route_old_head", at(obs_rv, 0), 6);
        check("pushpop_grant", at(obs_gnt, 2), 8);
        drain();

        // Response with empty FIFO: error is sticky until reset.
        apply_reset();
        bus.data_r_valid_i = 1'b1;
        cycle();
        bus.data_r_valid_i = 1'b0;
        check("empty_resp_err", resp_err, 1);
        for (int c = 0; c < 5; c++) cycle();
        check("empty_resp_sticky", resp_err, 1);

        // Reset with 3 in flight, then 15 and 0 compete from a cleared pointer.
        apply_reset();
        bus.data_gnt_i = 1'b1;
        raise(1); raise(2); raise(3);
        for (int c = 0; c < 3; c++) begin
            cycle(); drop_granted();
        end
        check("inflight_before_reset", outstanding, 3);
        apply_reset();
        bus.data_r_valid_i = 1'b1;
        cycle();
        bus.data_r_valid_i = 1'b0;
        check("late_resp_err", resp_err, 1);
        bus.data_gnt_i = 1'b1;
        raise(15); raise(0);
        cycle(); drop_granted();
        cycle(); drop_granted();
        check("post_reset_first", at(obs_gnt, 0), 0);
        check("post_reset_second", at(obs_gnt, 1), 15);
        drain();

        // Randomized traffic honoring the hold-until-grant rule.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.data_gnt_i     = ($urandom_range(0, 9) < 7);
            bus.data_r_valid_i = (m_fifo.size() > 0) && ($urandom_range(0, 2) == 0);
            bus.data_r_rdata_i = $urandom;
            bus.data_r_opc_i   = 1'($urandom_range(0, 1));
            bus.data_r_aux_i   = XW'($urandom);
            for (int i = 0; i < N; i++)
                if (!bus.data_req_i[i] && $urandom_range(0, 7) == 0) raise(i);
            cycle();
            if (last_gnt != '0) begin
                if ($urandom_range(0, 1) == 0) drop_granted();
                else raise(onehot_idx(last_gnt));
            end
        end
        bus.data_req_i = '0;
        drain();
        check("final_outstanding", outstanding, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
